multiply_seq: RTL

//  Multi-cycle shift-add multiplier; the inverse companion of the combinational divider in the mini CPU ALU.

---
 rtl/multiply_seq_if.sv | 23 ++
 rtl/multiply_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/multiply_seq_if.sv
// rtl/multiply_seq_if.sv - request/response bundle for the sequential multiplier
interface multiply_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  modport master (
    output start, signed_op, A, B,
    input  busy, done, product_hi, product_lo
  );

  modport slave (
    input  start, signed_op, A, B,
    output busy, done, product_hi, product_lo
  );
endinterface

// File: rtl/multiply_seq.sv
// rtl/multiply_seq.sv - multi-cycle shift-add multiplier, signed and unsigned
// Magnitudes are multiplied unsigned; the sign is reapplied once when the product is written.
module multiply_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  multiply_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [WIDTH-1:0]   prod_hi;
  logic [WIDTH-1:0]   prod_lo;

  logic               accept;
  logic               step;
  logic               finish;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state != IDLE);
    bus.done       = (state == DONE);
    bus.product_hi = prod_hi;
    bus.product_lo = prod_lo;
  end

  // The most negative operand negates to itself, which is exactly its unsigned magnitude.
  always_comb begin
    accept  = (state == IDLE) && bus.start;
    step    = (state == RUN) && (cnt != CW'(WIDTH));
    finish  = (state == RUN) && (cnt == CW'(WIDTH));
    a_mag   = (bus.signed_op && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag   = (bus.signed_op && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    result  = neg ? -acc : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      prod_hi <= '0;
      prod_lo <= '0;
    end else begin
      if (accept) begin
        mcand  <= a_mag;
        mplier <= b_mag;
        neg    <= bus.signed_op & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
        acc    <= '0;
        cnt    <= '0;
      end else if (step) begin
        // Carry out of the upper-half add lands in the top bit after the shift.
        acc    <= {partial, acc[WIDTH-1:1]};
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
      if (finish) begin
        prod_hi <= result[2*WIDTH-1:WIDTH];
        prod_lo <= result[WIDTH-1:0];
      end
    end
  end
endmodule
